// File: rtl/pipeline_param_if.sv
// Instruction issue, retire and debug-read signals of the four-stage ALU pipeline.
// The bench drives through master; the pipeline itself uses slave.
interface pipeline_param_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 8
);
  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

  logic          in_valid;
  logic [RW-1:0] rs1;
  logic [RW-1:0] rs2;
  logic [RW-1:0] rd;
  logic [3:0]    func;
  logic [AW-1:0] addr;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] Zout;
  logic          out_valid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output in_valid, rs1, rs2, rd, func, addr, mem_raddr,
    input  Zout, out_valid, mem_rdata
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, func, addr, mem_raddr,
    output Zout, out_valid, mem_rdata
  );
endinterface

// File: rtl/pipeline_param.sv
// Four-stage register-bank ALU pipeline: operand fetch with two-level bypass, ALU,
// register write-back plus Zout, then a memory write of the result.
module pipeline_param #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 8
) (
  input logic             clk,
  input logic             rst_n,
  pipeline_param_if.slave bus
);
  localparam int unsigned RW    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned Depth = 1 << AW;
  localparam logic [RW:0] NRegW = (RW + 1)'(NREG);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpMul  = 4'd2;
  localparam logic [3:0] OpPasA = 4'd3;
  localparam logic [3:0] OpPasB = 4'd4;
  localparam logic [3:0] OpAnd  = 4'd5;
  localparam logic [3:0] OpOr   = 4'd6;
  localparam logic [3:0] OpXor  = 4'd7;
  localparam logic [3:0] OpNegA = 4'd8;
  localparam logic [3:0] OpNegB = 4'd9;
  localparam logic [3:0] OpSrl  = 4'd10;
  localparam logic [3:0] OpSll  = 4'd11;

  function automatic logic idx_ok(input logic [RW-1:0] idx);
    return {1'b0, idx} < NRegW;
  endfunction

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] mem_q [Depth];

  // S1: fetched operands
  logic          s1_valid_q, s1_wr_q;
  logic [RW-1:0] s1_rd_q;
  logic [3:0]    s1_func_q;
  logic [AW-1:0] s1_addr_q;
  logic [DW-1:0] s1_a_q, s1_b_q;

  // S2: ALU result awaiting write-back
  logic          s2_valid_q, s2_wr_q;
  logic [RW-1:0] s2_rd_q;
  logic [AW-1:0] s2_addr_q;
  logic [DW-1:0] s2_z_q;

  // S3: retired result, also the memory write data
  logic          out_valid_q;
  logic [DW-1:0] zout_d, zout_q;
  logic [AW-1:0] s3_addr_q;

  logic [DW-1:0] alu_z;
  logic [RW-1:0] rs_idx [2];
  logic [DW-1:0] opnd [2];

  always_comb begin
    unique case (s1_func_q)
      OpAdd:   alu_z = s1_a_q + s1_b_q;
      OpSub:   alu_z = s1_a_q - s1_b_q;
      OpMul:   alu_z = s1_a_q * s1_b_q;
      OpPasA:  alu_z = s1_a_q;
      OpPasB:  alu_z = s1_b_q;
      OpAnd:   alu_z = s1_a_q & s1_b_q;
      OpOr:    alu_z = s1_a_q | s1_b_q;
      OpXor:   alu_z = s1_a_q ^ s1_b_q;
      OpNegA:  alu_z = '0 - s1_a_q;
      OpNegB:  alu_z = '0 - s1_b_q;
      OpSrl:   alu_z = s1_a_q >> 1;
      OpSll:   alu_z = s1_a_q << 1;
      default: alu_z = '0;
    endcase
  end

  // Younger in-flight result wins; only stages that will really write are sources.
  always_comb begin
    rs_idx[0] = bus.rs1;
    rs_idx[1] = bus.rs2;
    for (int i = 0; i < 2; i++) begin
      opnd[i] = '0;
      if (idx_ok(rs_idx[i])) begin
        if (s1_wr_q && (s1_rd_q == rs_idx[i])) begin
          opnd[i] = alu_z;
        end else if (s2_wr_q && (s2_rd_q == rs_idx[i])) begin
          opnd[i] = s2_z_q;
        end else begin
          opnd[i] = rf_q[rs_idx[i]];
        end
      end
    end
  end

  always_comb begin
    zout_d = zout_q;
    if (s2_valid_q) begin
      zout_d = s2_z_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_wr_q     <= 1'b0;
      s1_rd_q     <= '0;
      s1_func_q   <= '0;
      s1_addr_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_wr_q     <= 1'b0;
      s2_rd_q     <= '0;
      s2_addr_q   <= '0;
      s2_z_q      <= '0;
      out_valid_q <= 1'b0;
      zout_q      <= '0;
      s3_addr_q   <= '0;
    end else begin
      s1_valid_q  <= bus.in_valid;
      s1_wr_q     <= bus.in_valid && idx_ok(bus.rd);
      s1_rd_q     <= bus.rd;
      s1_func_q   <= bus.func;
      s1_addr_q   <= bus.addr;
      s1_a_q      <= opnd[0];
      s1_b_q      <= opnd[1];
      s2_valid_q  <= s1_valid_q;
      s2_wr_q     <= s1_wr_q;
      s2_rd_q     <= s1_rd_q;
      s2_addr_q   <= s1_addr_q;
      s2_z_q      <= alu_z;
      out_valid_q <= s2_valid_q;
      zout_q      <= zout_d;
      s3_addr_q   <= s2_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        rf_q[k] <= DW'(k);
      end
    end else if (s2_wr_q) begin
      rf_q[s2_rd_q] <= s2_z_q;
    end
  end

  // Memory keeps its contents across reset; the cleared valid bit blocks stale writes.
  always_ff @(posedge clk) begin
    if (out_valid_q) begin
      mem_q[s3_addr_q] <= zout_q;
    end
  end

  assign bus.Zout      = zout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mem_rdata = mem_q[bus.mem_raddr];
endmodule

// File: doc/pipeline_param.md
PIPELINE_PARAM -- requirements
Module: pipeline_param

Interface
REQ-001 The block SHALL provide parameter DW, default 16, meaning data/register width in bits.
REQ-002 The block SHALL provide parameter NREG, default 16, meaning register-bank entries; register index width RW = clog2(NREG).
REQ-003 The block SHALL provide parameter AW, default 8, meaning memory address width; memory depth 2**AW words of DW bits.
REQ-004 Port clk  input  1  meaning single pipeline clock, all state on rising edge.
REQ-005 Port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1  meaning instruction on rs1/rs2/rd/func/addr is valid this cycle.
REQ-007 Port rs1, rs2, rd  input  RW each  meaning source A, source B, destination register indices.
REQ-008 Port func  input  4  meaning ALU opcode.
REQ-009 Port addr  input  AW  meaning memory address receiving the result.
REQ-010 Port mem_raddr  input  AW  meaning debug memory read address.
REQ-011 Port Zout  output  DW  meaning result of the instruction retiring from stage 3.
REQ-012 Port out_valid  output  1  meaning Zout updated on the last edge by a valid instruction.
REQ-013 Port mem_rdata  output  DW  meaning combinational memory[mem_raddr].

Function
REQ-014 Four stages SHALL exist: S1 operand fetch (edge E0), S2 ALU (E1), S3 regbank write + Zout (E2), S4 memory write (E3).
REQ-015 An instruction sampled at E0 SHALL drive Zout/out_valid after E2 and write memory[addr] at E3; throughput one instruction per clock, no stalls.
REQ-016 Opcodes SHALL be: 0 A+B, 1 A-B, 2 A*B, 3 A, 4 B, 5 A&B, 6 A|B, 7 A^B, 8 -A, 9 -B, 10 A>>1 logical, 11 A<<1; 12-15 result 0.
REQ-017 All arithmetic SHALL be modulo 2**DW; MUL keeps low DW bits of the product; NEG is two's complement.
REQ-018 At E2 a valid instruction SHALL write regbank[rd] = Z; at E3 memory[addr] = Z.
REQ-019 Operand fetch SHALL bypass: if the instruction in S2 (ALU output) is valid with rd == rsX, use the ALU output; else if the instruction in S3 is valid with rd == rsX, use its result; else regbank[rsX]; S2 has priority over S3.
REQ-020 rs1 == rs2 SHALL bypass both operands identically; an instruction whose rd equals its own rs reads the pre-write value.
REQ-021 in_valid = 0 SHALL propagate a bubble: no regbank write, no memory write, out_valid 0 for that slot, Zout holds its last value.
REQ-022 Invalid stages SHALL never be bypass sources.
REQ-023 Same rd written by two consecutive instructions SHALL leave the younger result; same addr likewise at memory.
REQ-024 rs/rd indices >= NREG (non-power-of-two NREG) SHALL read 0 and suppress the regbank write.

Reset
REQ-025 rst_n low SHALL immediately clear all stage valid bits, Zout = 0, out_valid = 0, and load regbank[k] = k (truncated to DW).
REQ-026 Memory contents SHALL NOT be reset; instructions in flight at reset assertion SHALL be discarded with no regbank or memory write after assertion.
REQ-027 The first instruction sampled SHALL be the one with in_valid high at the first rising edge after rst_n deasserts.

Verification
REQ-028 DW=16: after reset, ADD rs1=3 rs2=5 rd=1 addr=1 -> Zout=8, out_valid=1 after E2; mem_rdata at addr 1 = 8 after E3; regbank[1]=8.
REQ-029 Back-to-back: ADD 3+5 rd=1, next cycle MUL rs1=1 rs2=2 rd=2 addr=2 -> Zout=16 (S2 bypass), mem[2]=16.
REQ-030 Gap of one: ADD 3+5 rd=1, then SUB 10-0 rd=3, then SLA rs1=1 rd=4 addr=4 -> Zout sequence 8, 10, 16 (S3 bypass).
REQ-031 DW=8: ADD 15+15 rd=1, next MUL rs1=1 rs2=1 rd=2 -> Zout=30 then 132 (900 mod 256); NEG r1 -> 226.
REQ-032 Bubble: ADD 3+5 rd=1, in_valid=0 one cycle, ADD 1+1 rd=6 -> out_valid 1,0,1; Zout 8, 8 held, 16.
REQ-033 Reset mid-flight: three valid instructions issued, rst_n pulsed low between E1 and E2 of the first -> Zout=0, out_valid=0, regbank[k]=k, no memory write at those addrs.
